// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master to one-slave Wishbone B3 classic arbiter
//
// Purpose:
//   Shares one on-chip RAM slave between the core fetch port (m0) and the
//   debug/loader port (m1). The grant is registered and round-robin fair, and
//   it is held for the whole cyc of the granted master. Once a master is
//   granted, the slave data path is a pure combinational mux, so the arbiter
//   adds no latency to the slave's own ack/data timing.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   When defined, a stall counter aborts a granted strobe that has waited
//   TIMEOUT_CYCLES-1 cycles without ack. The granted master sees err for one
//   cycle, the slave sees cyc/stb dropped, and the grant passes on. When
//   undefined, no counter is built and m*_err_o are tied low.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   m0_*/m1_* inputs      master adr/dat/we/sel/stb/cyc requests
//   m0_*/m1_* outputs     read data, ack and err back to each master
//   s_*_o                 muxed request to the slave
//   s_dat_i, s_ack_i      slave read data and acknowledge

module wb_arbiter_2m #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,

  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,

  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic                    s_ack_i
);

  // The counter must be able to reach TIMEOUT_CYCLES-1 at least once.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Round-robin pointer: 0 -> m0 wins a tie, 1 -> m1 wins a tie.
  logic   ptr, ptr_nxt;

  // Request of whichever master currently holds the grant.
  logic   gnt_cyc;
  logic   gnt_stb;

  // High in the single cycle where a stalled strobe is aborted.
  logic   timeout;

  always_comb begin
    gnt_cyc = 1'b0;
    gnt_stb = 1'b0;
    case (state)
      GNT0: begin
        gnt_cyc = m0_cyc_i;
        gnt_stb = m0_cyc_i & m0_stb_i;
      end
      GNT1: begin
        gnt_cyc = m1_cyc_i;
        gnt_stb = m1_cyc_i & m1_stb_i;
      end
      default: begin
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;

  // Abort is qualified by the live ack: a slave answering on the very last
  // cycle still completes normally.
  assign timeout = gnt_stb & ~s_ack_i & (stall_cnt == CNT_LIMIT);

  always_comb begin
    stall_cnt_nxt = '0;
    if (gnt_stb && !s_ack_i && !timeout) begin
      stall_cnt_nxt = stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and pointer. The pointer only moves when a grant ends, so a
  // master that just finished loses the next tie.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = ptr ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || timeout) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || timeout) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Datapath mux. Everything toward the slave is zero unless the granted
  // master still holds cyc, which also blanks the cycle in which a grant ends.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        if (gnt_cyc) begin
          s_adr_o = m0_adr_i;
          s_dat_o = m0_dat_i;
          s_we_o  = m0_we_i;
          s_sel_o = m0_sel_i;
          s_stb_o = gnt_stb & ~timeout;
          s_cyc_o = ~timeout;
        end
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = timeout;
      end
      GNT1: begin
        if (gnt_cyc) begin
          s_adr_o = m1_adr_i;
          s_dat_o = m1_dat_i;
          s_we_o  = m1_we_i;
          s_sel_o = m1_sel_i;
          s_stb_o = gnt_stb & ~timeout;
          s_cyc_o = ~timeout;
        end
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = timeout;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - self-checking bench for wb_arbiter_2m

module tb_wb_arbiter_2m;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_we_i, m1_we_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic          m0_stb_i, m1_stb_i;
  logic          m0_cyc_i, m1_cyc_i;
  logic          m0_ack_o, m1_ack_o;
  logic          m0_err_o, m1_err_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i;
  logic          s_we_o;
  logic [SW-1:0] s_sel_o;
  logic          s_stb_o;
  logic          s_cyc_o;
  logic          s_ack_i;
  logic          slave_en;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  wb_arbiter_2m #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
    .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
    .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0FFE, a};
  endfunction

  // Zero-wait slave: acks every strobe in the same cycle while enabled.
  assign s_ack_i = slave_en & s_cyc_o & s_stb_o;
  assign s_dat_i = rd_val(s_adr_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic cyc, input logic we,
                     input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we;
      m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = 4'hF;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we;
      m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = 4'hF;
    end
  endtask

  task automatic push(input int m, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] wdat);
    beat_t b;
    b.m   = m;
    b.we  = we;
    b.adr = adr;
    b.dat = we ? wdat : rd_val(adr);
    b.sel = 4'hF;
    exp_q.push_back(b);
  endtask

  // Scoreboard: every completed slave beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && s_cyc_o && s_stb_o && s_ack_i) begin
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_m1_ack", m1_ack_o, mon_e.m == 1);
        chk("sb_m0_ack", m0_ack_o, mon_e.m == 0);
        chk("sb_adr", s_adr_o, mon_e.adr);
        chk("sb_we", s_we_o, mon_e.we);
        chk("sb_sel", s_sel_o, mon_e.sel);
        if (mon_e.we) chk("sb_wdat", s_dat_o, mon_e.dat);
        else chk("sb_rdat", (mon_e.m == 1) ? m1_dat_o : m0_dat_o, mon_e.dat);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    slave_en = 1'b0;
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    step(); step();
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_we", s_we_o, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_s_dat", s_dat_o, 0);
    chk("rst_s_sel", s_sel_o, 0);
    chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("rst_m_dat", {m0_dat_o, m1_dat_o}, 0);
    rst_n = 1'b1;

    // m0 single read of 0x010
    step();
    slave_en = 1'b1;
    drv(0, 1, 0, 12'h010, '0);
    push(0, 0, 12'h010, '0);
    #1 chk("t1_idle_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t1_gnt_cyc", s_cyc_o, 1);
    chk("t1_m0_ack", m0_ack_o, 1);
    chk("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
    chk("t1_m1_ack", m1_ack_o, 0);
    step();
    drv(0, 0, 0, '0, '0);
    #1 chk("t1_leave_cyc", s_cyc_o, 0);
    step();

    // Pointer now at m1: tie goes to m1, which holds cyc for three writes
    drv(0, 1, 0, 12'h020, '0);
    drv(1, 1, 1, 12'h000, 32'h1);
    push(1, 1, 12'h000, 32'h1);
    #1 chk("t3_idle_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t3_b0_m1_ack", m1_ack_o, 1);
    chk("t3_b0_m0_ack", m0_ack_o, 0);
    for (int i = 1; i < 3; i++) begin
      step();
      drv(1, 1, 1, AW'(4 * i), DW'(i + 1));
      push(1, 1, AW'(4 * i), DW'(i + 1));
      #1;
      chk("t3_bn_s_dat", s_dat_o, DW'(i + 1));
      chk("t3_bn_m0_ack", m0_ack_o, 0);
    end
    step();
    drv(1, 0, 0, '0, '0);
    push(0, 0, 12'h020, '0);
    #1 chk("t3_leave_cyc", s_cyc_o, 0);
    chk("t3_leave_m0_ack", m0_ack_o, 0);
    step(); #1;
    chk("t3_gap_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t3_m0_adr", s_adr_o, 12'h020);
    chk("t3_m0_ack", m0_ack_o, 1);
    step();
    drv(0, 0, 0, '0, '0);
    step();

    // After reset, simultaneous requests: m0, then m1, then m0 again
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drv(0, 1, 0, 12'h040, '0);
    drv(1, 1, 0, 12'h044, '0);
    push(0, 0, 12'h040, '0);
    #1 chk("t2_idle_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t2_m0_first", s_adr_o, 12'h040);
    chk("t2_m1_wait", m1_ack_o, 0);
    step();
    drv(0, 0, 0, '0, '0);
    push(1, 0, 12'h044, '0);
    #1 chk("t2_leave_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t2_gap_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t2_m1_adr", s_adr_o, 12'h044);
    chk("t2_m1_ack", m1_ack_o, 1);
    step();
    drv(1, 0, 0, '0, '0);
    step();
    drv(0, 1, 0, 12'h048, '0);
    drv(1, 1, 0, 12'h04C, '0);
    push(0, 0, 12'h048, '0);
    step(); #1;
    chk("t2_again_m0", s_adr_o, 12'h048);
    chk("t2_again_m0_ack", m0_ack_o, 1);
    step();
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    step();

    // Asynchronous reset while m1 is granted and stalled
    slave_en = 1'b0;
    drv(1, 1, 0, 12'h050, '0);
    step(); #1;
    chk("t4_gnt_stb", s_stb_o, 1);
    #1;
    rst_n = 1'b0;
    drv(0, 1, 0, 12'h054, '0);
    #1;
    chk("t4_async_cyc", s_cyc_o, 0);
    chk("t4_async_stb", s_stb_o, 0);
    chk("t4_async_adr", s_adr_o, 0);
    chk("t4_async_m1_ack", m1_ack_o, 0);
    step();
    rst_n = 1'b1;
    #1 chk("t4_post_idle", s_cyc_o, 0);
    push(0, 0, 12'h054, '0);
    slave_en = 1'b1;
    step(); #1;
    chk("t4_ptr_m0", s_adr_o, 12'h054);
    chk("t4_m1_ack", m1_ack_o, 0);
    step();
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    step();

    // Stalled slave on m0 with m1 pending
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    slave_en = 1'b0;
    drv(0, 1, 0, 12'h060, '0);
    drv(1, 1, 0, 12'h064, '0);
    step(); #1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      chk("t5_no_err", m0_err_o, 0);
      chk("t5_cyc_held", s_cyc_o, 1);
      step(); #1;
    end
    chk("t5_err", m0_err_o, 1);
    chk("t5_err_cyc", s_cyc_o, 0);
    chk("t5_err_stb", s_stb_o, 0);
    chk("t5_m1_err", m1_err_o, 0);
    push(1, 0, 12'h064, '0);
    slave_en = 1'b1;
    step();
    drv(0, 0, 0, '0, '0);
    #1 chk("t5_err_once", m0_err_o, 0);
    chk("t5_gap_cyc", s_cyc_o, 0);
    step(); #1;
    chk("t5_m1_gnt", s_adr_o, 12'h064);
    chk("t5_m1_ack", m1_ack_o, 1);
    step();
    drv(1, 0, 0, '0, '0);
`else
    for (int i = 0; i < 110; i++) begin
      chk("t5_no_err", m0_err_o, 0);
      chk("t5_cyc_held", s_cyc_o, 1);
      step(); #1;
    end
    push(0, 0, 12'h060, '0);
    slave_en = 1'b1;
    #1 chk("t5_late_ack", m0_ack_o, 1);
    step();
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
`endif
    step(); step(); step();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone B3 classic arbiter.
- Sits directly upstream of the on-chip RAM slave. Lets the core fetch port (m0) and the debug/loader port (m1) share one RAM.
- Registered grant with round-robin fairness. The grant is held for a master's whole cyc.
- Adds no extra latency to the slave's own data path once granted.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8/16/32/64).
- ADDR_WIDTH, 12, byte address width.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 16, stall limit before a bus error (used only with the optional feature). Must be ≥2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_adr_i, m1_adr_i  input  ADDR_WIDTH each  master addresses.
- m0_dat_i, m1_dat_i  input  DATA_WIDTH each  master write data.
- m0_dat_o, m1_dat_o  output  DATA_WIDTH each  read data returned to the masters.
- m0_we_i, m1_we_i  input  1 each  write enables.
- m0_sel_i, m1_sel_i  input  SELECT_WIDTH each  byte selects.
- m0_stb_i, m1_stb_i  input  1 each  strobes.
- m0_cyc_i, m1_cyc_i  input  1 each  cycle requests.
- m0_ack_o, m1_ack_o  output  1 each  acknowledges.
- m0_err_o, m1_err_o  output  1 each  bus error (timeout).
- s_adr_o  output  ADDR_WIDTH  address to the slave.
- s_dat_o  output  DATA_WIDTH  write data to the slave.
- s_dat_i  input  DATA_WIDTH  read data from the slave.
- s_we_o  output  1  write enable to the slave.
- s_sel_o  output  SELECT_WIDTH  byte selects to the slave.
- s_stb_o  output  1  strobe to the slave.
- s_cyc_o  output  1  cycle to the slave.
- s_ack_i  input  1  acknowledge from the slave.

Behaviour:
- Interface is decided: single clock clk; rst_n is asynchronous, active-low.
- Reset state:
  - state=IDLE, priority pointer=m0, timeout counter=0.
  - All m*_ack_o, m*_err_o, s_cyc_o, s_stb_o, s_we_o = 0.
  - s_adr_o, s_dat_o, s_sel_o = 0; m*_dat_o = 0.
- FSM states: IDLE, GNT0, GNT1 (registered).
- IDLE transitions:
  - Only m0_cyc_i=1 -> GNT0.
  - Only m1_cyc_i=1 -> GNT1.
  - Both asserted -> the master named by the pointer wins.
  - Neither asserted -> stay IDLE.
- Arbitration latency: exactly 1 cycle. The request is sampled in IDLE, and slave outputs follow the winner from the next cycle.
- GNTn datapath:
  - s_adr_o/s_dat_o/s_we_o/s_sel_o/s_stb_o/s_cyc_o are a combinational mux of master n.
  - mn_ack_o = s_ack_i, and mn_dat_o = s_dat_i.
  - The other master sees ack=0, err=0, dat_o=0.
- Leaving GNTn: when mn_cyc_i=0, go to IDLE and set the pointer to the other master. Slave outputs are 0 in that cycle and in IDLE.
- No preemption. A master holding cyc across several stb/ack beats keeps the grant indefinitely.
- Re-arbitration takes 1 IDLE cycle minimum between grants, even if the other master is already waiting.
- A strobe from a non-granted master is ignored. It gets no ack and stalls until granted.
- The slave acks at most once per strobe. The arbiter passes ack through unmodified and never generates ack itself.
- Reset mid-transfer: outputs clear immediately (async). Any in-flight slave ack after reset release is dropped, because state=IDLE.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - In GNTn, the counter increments every cycle with s_stb_o=1 and s_ack_i=0. It clears on ack, on an IDLE transition, or when stb=0.
  - When the counter reaches TIMEOUT_CYCLES-1 and ack is still 0: assert mn_err_o for exactly 1 cycle. In the same cycle force s_cyc_o=s_stb_o=0.
  - Next state IDLE; pointer moves to the other master.
- Without the macro: the counter is not built, m*_err_o are tied 0, and a stalled slave stalls forever.

Test Plan:
- Reset, then m0 read of adr 0x010 with the slave returning 0xDEADBEEF on ack -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_dat_o=0xDEADBEEF with m0_ack_o; m1_ack_o stays 0.
- m0 and m1 raise cyc in the same cycle after reset -> m0 granted first. After m0 drops cyc: 1 IDLE cycle, then m1 granted. Repeat with both again -> m0 granted (alternation confirmed).
- m1 holds cyc for 3 back-to-back writes (0x1,0x2,0x3 to adr 0x0/0x4/0x8, sel=0xF) while m0 requests -> m0 is not granted until m1 drops cyc; slave sees all 3 writes from m1.
- rst_n pulsed low mid-grant with s_stb_o=1 -> s_cyc_o/s_stb_o/acks go to 0 asynchronously. After release, state=IDLE and the pointer is back at m0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks m0 -> m0_err_o=1 for 1 cycle, 15 cycles after the first granted stb; s_cyc_o=0 that cycle; pending m1 is then granted.
- Without the macro, same stall -> m0_err_o stays 0 and s_cyc_o stays 1 for 100+ cycles.
